// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on load/ready
// and shifts it out one bit per clock with a valid strobe and end-of-word pulse.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sreg_next;

    assign last_bit = (state == SHIFT) && (cnt == '0);
    assign ready    = (state == IDLE) || last_bit;
    assign accept   = load && ready;

    // Move the next bit toward the output end, zero-filling behind it.
    always_comb begin
        sreg_next = '0;
        if (MSB_FIRST)
            sreg_next = {sreg[WIDTH-2:0], 1'b0};
        else
            sreg_next = {1'b0, sreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= last_bit;
            if (accept) begin
                sreg  <= data_in;
                cnt   <= CNT_LAST;
                state <= SHIFT;
            end else if (state == SHIFT) begin
                if (cnt != '0) begin
                    sreg <= sreg_next;
                    cnt  <= cnt - CW'(1);
                end else begin
                    sreg  <= '0;
                    state <= IDLE;
                end
            end
        end
    end

    // Outputs decode straight from reset registers, so an async reset clears them at once.
    assign serial_valid = (state == SHIFT);
    assign serial_out   = serial_valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance share stimulus and are
// checked every cycle against a bit-queue model, plus hand-computed word expectations.
module tb_piso_tx;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;

    logic rdy_m, so_m, sv_m, dn_m;
    logic rdy_l, so_l, sv_l, dn_l;
    logic rdy[2], so[2], sv[2], dn[2];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .ready(rdy_m), .serial_out(so_m), .serial_valid(sv_m), .done(dn_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .ready(rdy_l), .serial_out(so_l), .serial_valid(sv_l), .done(dn_l)
    );

    always_comb begin
        rdy[0] = rdy_m; so[0] = so_m; sv[0] = sv_m; dn[0] = dn_m;
        rdy[1] = rdy_l; so[1] = so_l; sv[1] = sv_l; dn[1] = dn_l;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int d, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, d, got, exp, $time);
        end
    endtask

    // Model: a FIFO of bits still to be sent; its head is the bit on the wire now.
    logic eb[2][256];
    logic el[2][256];
    int   head[2] = '{0, 0};
    int   tail[2] = '{0, 0};
    logic dexp[2] = '{1'b0, 1'b0};
    int   m_n;
    bit   m_acc;

    initial forever begin
        @(posedge clk or posedge rst);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                head[d] = 0;
                tail[d] = 0;
                dexp[d] = 1'b0;
            end else begin
                m_n     = tail[d] - head[d];
                m_acc   = load && (m_n <= 1);
                dexp[d] = 1'b0;
                if (m_n > 0) begin
                    dexp[d] = el[d][head[d] % 256];
                    head[d]++;
                end
                if (m_acc) begin
                    for (int i = 0; i < W; i++) begin
                        eb[d][tail[d] % 256] = (d == 0) ? data_in[W-1-i] : data_in[i];
                        el[d][tail[d] % 256] = (i == W - 1);
                        tail[d]++;
                    end
                end
            end
        end
    end

    // Per-cycle compare plus a sipo-style collector for the word-level checks.
    logic [15:0] cap[2]   = '{16'h0, 16'h0};
    int          nv[2]    = '{0, 0};
    int          nd[2]    = '{0, 0};
    logic [3:0]  wrd[2]   = '{4'h0, 4'h0};
    logic [3:0]  rxlog[2][64];
    int          c_n;

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            c_n = tail[d] - head[d];
            chk("ready", d, 16'(rdy[d]), 16'(c_n <= 1));
            chk("serial_valid", d, 16'(sv[d]), 16'(c_n > 0));
            chk("serial_out", d, 16'(so[d]), 16'((c_n > 0) ? eb[d][head[d] % 256] : 1'b0));
            chk("done", d, 16'(dn[d]), 16'(dexp[d]));
            if (dn[d] === 1'b1) begin
                rxlog[d][nd[d] % 64] = wrd[d];
                nd[d]++;
            end
            if (sv[d] === 1'b1) begin
                cap[d] = {cap[d][14:0], so[d]};
                nv[d]++;
                wrd[d] = (d == 0) ? {wrd[d][2:0], so[d]} : {so[d], wrd[d][3:1]};
            end
        end
    end

    task automatic drv(input logic l, input logic [3:0] d);
        @(negedge clk);
        load    = l;
        data_in = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 4'($urandom));
    endtask

    int v0, d0, i0;

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst ready", 0, 16'(rdy_m), 16'd1);
        chk("rst valid", 0, 16'(sv_m), 16'd0);
        chk("rst out", 0, 16'(so_m), 16'd0);
        chk("rst done", 0, 16'(dn_m), 16'd0);

        // 1: single word 4'hA
        v0 = nv[0]; d0 = nd[0];
        drv(1'b1, 4'hA);
        idle(6); #1;
        chk("t1 msb bits", 0, 16'(cap[0][3:0]), 16'hA);
        chk("t1 lsb bits", 1, 16'(cap[1][3:0]), 16'h5);
        chk("t1 valid cycles", 0, 16'(nv[0] - v0), 16'd4);
        chk("t1 done pulses", 0, 16'(nd[0] - d0), 16'd1);

        // 2: single word 4'hC
        v0 = nv[1]; d0 = nd[1];
        drv(1'b1, 4'hC);
        idle(6); #1;
        chk("t2 msb bits", 0, 16'(cap[0][3:0]), 16'hC);
        chk("t2 lsb bits", 1, 16'(cap[1][3:0]), 16'h3);
        chk("t2 valid cycles", 1, 16'(nv[1] - v0), 16'd4);
        chk("t2 done pulses", 1, 16'(nd[1] - d0), 16'd1);

        // 3: back-to-back 4'h9 then 4'h6
        v0 = nv[0]; d0 = nd[0];
        drv(1'b1, 4'h9);
        idle(3);
        drv(1'b1, 4'h6);
        idle(7); #1;
        chk("t3 msb stream", 0, 16'(cap[0][7:0]), 16'h96);
        chk("t3 lsb stream", 1, 16'(cap[1][7:0]), 16'h96);
        chk("t3 valid cycles", 0, 16'(nv[0] - v0), 16'd8);
        chk("t3 done pulses", 0, 16'(nd[0] - d0), 16'd2);

        // 4: loads while busy are ignored
        v0 = nv[0]; d0 = nd[0];
        drv(1'b1, 4'hF);
        drv(1'b1, 4'h0); #1;
        chk("t4 busy ready", 0, 16'(rdy_m), 16'd0);
        drv(1'b1, 4'h0);
        drv(1'b1, 4'h0);
        idle(6); #1;
        chk("t4 bits", 0, 16'(cap[0][3:0]), 16'hF);
        chk("t4 valid cycles", 0, 16'(nv[0] - v0), 16'd4);
        chk("t4 done pulses", 0, 16'(nd[0] - d0), 16'd1);

        // 5: async reset during bit 2 aborts the word
        drv(1'b1, 4'hA);
        drv(1'b0, 4'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5 async valid", 0, 16'(sv_m), 16'd0);
        chk("t5 async out", 0, 16'(so_m), 16'd0);
        chk("t5 async ready", 0, 16'(rdy_m), 16'd1);
        chk("t5 async valid lsb", 1, 16'(sv_l), 16'd0);
        d0 = nd[0];
        @(negedge clk);
        rst = 1'b0;
        idle(3); #1;
        chk("t5 no done", 0, 16'(nd[0] - d0), 16'd0);
        v0 = nv[0]; d0 = nd[0];
        drv(1'b1, 4'h5);
        idle(6); #1;
        chk("t5 msb bits", 0, 16'(cap[0][3:0]), 16'h5);
        chk("t5 lsb bits", 1, 16'(cap[1][3:0]), 16'hA);
        chk("t5 valid cycles", 0, 16'(nv[0] - v0), 16'd4);
        chk("t5 done pulses", 0, 16'(nd[0] - d0), 16'd1);

        // 6: loopback into a deserializer, 4'h3 then 4'hE
        i0 = nd[0];
        drv(1'b1, 4'h3);
        idle(3);
        drv(1'b1, 4'hE);
        idle(7); #1;
        chk("t6 count", 0, 16'(nd[0] - i0), 16'd2);
        chk("t6 word0 msb", 0, 16'(rxlog[0][i0 % 64]), 16'h3);
        chk("t6 word1 msb", 0, 16'(rxlog[0][(i0 + 1) % 64]), 16'hE);
        chk("t6 word0 lsb", 1, 16'(rxlog[1][i0 % 64]), 16'h3);
        chk("t6 word1 lsb", 1, 16'(rxlog[1][(i0 + 1) % 64]), 16'hE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter. It is the send-side counterpart of the team's sipo receiver. It accepts a WIDTH-bit word through a load/ready handshake and shifts it out one bit per clock, with a qualifying valid strobe and an end-of-word pulse. It sits between a parallel word source and a serial link that feeds a sipo instance.

Parameters:
WIDTH, 4, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous active-high reset.
load  input  1  request to transmit data_in; accepted only when ready=1 at the rising edge.
data_in  input  WIDTH  parallel word; sampled on the accepting edge only.
ready  output  1  transmitter can accept a word on the next rising edge.
serial_out  output  1  current serial bit; forced 0 when serial_valid=0.
serial_valid  output  1  serial_out carries a data bit this cycle.
done  output  1  one-cycle pulse in the cycle after the last bit of a word.

Behaviour:
- Reset, asynchronous, immediate on rst=1: state=IDLE, shift register=0, bit counter=0, serial_out=0, serial_valid=0, done=0, ready=1. Reset mid-word aborts the word; no done pulse is produced for it.
- States: IDLE and SHIFT.
- Bit counter width is ceil(log2(WIDTH)). It holds the number of bits remaining after the current one.
- ready is combinational: 1 in IDLE, 1 in SHIFT when counter==0 (last bit), 0 otherwise.
- Accept means load=1 and ready=1 at a rising edge:
  - shift register <= data_in, counter <= WIDTH-1, state <= SHIFT.
  - The first bit appears on serial_out in the cycle immediately after the accepting edge (latency 1).
- In SHIFT:
  - serial_valid=1.
  - serial_out = shift register MSB if MSB_FIRST=1, else LSB.
  - Each rising edge with counter>0: shift toward the output end (left if MSB_FIRST, else right), zero-fill, counter decrements.
- Last bit (SHIFT and counter==0) at the rising edge:
  - If load=1, the new word is accepted (back-to-back). State stays SHIFT with no idle gap, and done pulses in the next cycle.
  - If load=0, the next state is IDLE, done pulses in the next cycle, and serial_valid drops to 0.
- done is registered. It is high for exactly one cycle after each completed word, and can coincide with the first bit of a back-to-back word.
- load while ready=0 is ignored. data_in changes while busy have no effect on the word in flight.
- The word occupies exactly WIDTH consecutive serial_valid cycles. Back-to-back streaming keeps serial_valid continuously high.
- In IDLE: serial_out=0 and serial_valid=0; load=0 holds IDLE.
- No X propagation: every register is reset, and every output is defined in every state.

Test Plan:
1. WIDTH=4, MSB_FIRST=1; after reset, check ready=1, serial_valid=0, serial_out=0, done=0. Pulse load with data_in=4'hA -> serial_out 1,0,1,0 on the next 4 cycles with serial_valid=1 -> done=1 in cycle 5, serial_valid=0, ready=1.
2. MSB_FIRST=0, data_in=4'hC -> serial_out 0,0,1,1; serial_valid high for exactly 4 cycles; one done pulse.
3. Back-to-back: load 4'h9, hold load=1 with data_in=4'h6 during the last bit -> serial stream 1,0,0,1,0,1,1,0 with serial_valid continuously high for 8 cycles. done pulses in cycle 5 (concurrent with the first bit of 4'h6) and in cycle 9.
4. Busy rejection: load 4'hF, then assert load with data_in=4'h0 during bits 1-3 -> stream stays 1,1,1,1; ready=0 during bits 1-3; only one done pulse.
5. Reset mid-word: load 4'hA, assert rst asynchronously between edges during bit 2 -> outputs go to reset values immediately without waiting for a clock edge. There is no done pulse, and a subsequent load of 4'h5 transmits 0,1,0,1 cleanly.
6. Loopback: connect serial_out/serial_valid to a sipo instance (load driven by serial_valid); send 4'h3, then 4'hE -> sipo data_out equals 4'h3, then 4'hE after each word.
